// File: rtl/pong_pkg.sv
// Shared pong definitions: game state encoding, winner codes and the
// default game constants, which the score-bar renderer also uses.
package pong_pkg;

  typedef enum logic [2:0] {
    MENU,
    SERVE,
    PLAY,
    SCORED,
    GAME_OVER
  } game_state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  localparam int unsigned DEF_WIN_SCORE    = 5;
  localparam int unsigned DEF_SERVE_FRAMES = 60;
  localparam int unsigned DEF_SCORE_W      = 10;

  // Add one to a score, but never go past the winning score.
  function automatic int unsigned sat_inc(input int unsigned v, input int unsigned lim);
    return (v >= lim) ? lim : v + 1;
  endfunction

endpackage

// File: rtl/score_keeper_if.sv
// Signal bundle between the score keeper and its neighbours.
//   Game events in : frame_tick, goal_p1, goal_p2, menu, start
//   Game status out: score1, score2, ball_release, playing, game_over, winner
// master = the side that supplies the events; slave = score_keeper.
interface score_keeper_if #(
  parameter int unsigned SCORE_W = pong_pkg::DEF_SCORE_W
);
  logic               frame_tick;
  logic               goal_p1;
  logic               goal_p2;
  logic               menu;
  logic               start;
  logic [SCORE_W-1:0] score1;
  logic [SCORE_W-1:0] score2;
  logic               ball_release;
  logic               playing;
  logic               game_over;
  logic [1:0]         winner;

  modport master (
    output frame_tick, goal_p1, goal_p2, menu, start,
    input  score1, score2, ball_release, playing, game_over, winner
  );

  modport slave (
    input  frame_tick, goal_p1, goal_p2, menu, start,
    output score1, score2, ball_release, playing, game_over, winner
  );
endinterface

// File: rtl/rise_detect.sv
// 1-bit synchronous rising-edge detector.
//   clock, reset : clock and synchronous active-high reset
//   d            : level input
//   rise         : high in the cycle where d=1 and its previous value was 0
module rise_detect (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic rise
);
  logic prev;

  always_ff @(posedge clock) begin
    if (reset) prev <= 1'b0;
    else       prev <= d;
  end

  assign rise = d & ~prev;
endmodule

// File: rtl/score_keeper.sv
// Game-state and score counter for two-player pong. Turns goal levels into
// single events, commits score changes only on frame ticks, runs the serve
// delay, detects the winner and pulses ball_release when play begins.
//   clock, reset : clock and synchronous active-high reset
//   bus (slave)  : frame_tick/goal_p1/goal_p2/menu/start in,
//                  score1/score2/ball_release/playing/game_over/winner out
import pong_pkg::*;

module score_keeper #(
  parameter int unsigned WIN_SCORE    = DEF_WIN_SCORE,
  parameter int unsigned SERVE_FRAMES = DEF_SERVE_FRAMES,
  parameter int unsigned SCORE_W      = DEF_SCORE_W
) (
  input  logic          clock,
  input  logic          reset,
  score_keeper_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(SERVE_FRAMES + 1);
  localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_FRAMES);
  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

  if (SERVE_FRAMES == 0) begin : g_bad_serve
    $error("score_keeper: SERVE_FRAMES must be at least 1");
  end
  if (WIN_SCORE == 0) begin : g_bad_win
    $error("score_keeper: WIN_SCORE must be at least 1");
  end

  game_state_t        state;
  logic [CNT_W-1:0]   serve_cnt;
  logic [1:0]         pend;
  logic [SCORE_W-1:0] score1, score2;
  logic [SCORE_W-1:0] inc1, inc2;
  logic               hit_win;
  logic               ball_release, playing, game_over;
  logic [1:0]         winner;
  logic               start_ev, g1_ev, g2_ev;

  rise_detect u_start (.clock(clock), .reset(reset), .d(bus.start),   .rise(start_ev));
  rise_detect u_g1    (.clock(clock), .reset(reset), .d(bus.goal_p1), .rise(g1_ev));
  rise_detect u_g2    (.clock(clock), .reset(reset), .d(bus.goal_p2), .rise(g2_ev));

  always_comb begin
    inc1    = SCORE_W'(sat_inc(32'(score1), WIN_SCORE));
    inc2    = SCORE_W'(sat_inc(32'(score2), WIN_SCORE));
    hit_win = (pend == WIN_P1) ? (inc1 == WIN_VAL) : (inc2 == WIN_VAL);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= MENU;
      serve_cnt    <= '0;
      pend         <= WIN_NONE;
      score1       <= '0;
      score2       <= '0;
      ball_release <= 1'b0;
      playing      <= 1'b0;
      game_over    <= 1'b0;
      winner       <= WIN_NONE;
    end else begin
      ball_release <= 1'b0;
      if (bus.menu) begin
        // Scores and winner stay so a paused game remains on screen.
        state     <= MENU;
        pend      <= WIN_NONE;
        serve_cnt <= '0;
        playing   <= 1'b0;
        game_over <= 1'b0;
      end else begin
        unique case (state)
          MENU: begin
            if (start_ev) begin
              score1    <= '0;
              score2    <= '0;
              winner    <= WIN_NONE;
              serve_cnt <= SERVE_LOAD;
              state     <= SERVE;
            end
          end
          SERVE: begin
            if (bus.frame_tick) begin
              serve_cnt <= serve_cnt - CNT_W'(1);
              if (serve_cnt == CNT_W'(1)) begin
                state        <= PLAY;
                ball_release <= 1'b1;
                playing      <= 1'b1;
              end
            end
          end
          PLAY: begin
            if (g1_ev && g2_ev) begin
              serve_cnt <= SERVE_LOAD;
              state     <= SERVE;
              playing   <= 1'b0;
            end else if (g1_ev) begin
              pend    <= WIN_P1;
              state   <= SCORED;
              playing <= 1'b0;
            end else if (g2_ev) begin
              pend    <= WIN_P2;
              state   <= SCORED;
              playing <= 1'b0;
            end
          end
          SCORED: begin
            // Holding the point until a tick keeps a frame from being torn.
            if (bus.frame_tick) begin
              if (pend == WIN_P1) score1 <= inc1;
              else                score2 <= inc2;
              pend <= WIN_NONE;
              if (hit_win) begin
                state     <= GAME_OVER;
                game_over <= 1'b1;
                winner    <= pend;
              end else begin
                serve_cnt <= SERVE_LOAD;
                state     <= SERVE;
              end
            end
          end
          GAME_OVER: begin
            if (start_ev) begin
              score1    <= '0;
              score2    <= '0;
              winner    <= WIN_NONE;
              serve_cnt <= SERVE_LOAD;
              game_over <= 1'b0;
              state     <= SERVE;
            end
          end
          default: state <= MENU;
        endcase
      end
    end
  end

  assign bus.score1       = score1;
  assign bus.score2       = score2;
  assign bus.ball_release = ball_release;
  assign bus.playing      = playing;
  assign bus.game_over    = game_over;
  assign bus.winner       = winner;
endmodule

// File: tb/tb_score_keeper.sv
module tb_score_keeper;
  localparam int WIN = 5;
  localparam int SF  = 3;

  logic clock = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  bit   chk_en = 1'b0;

  score_keeper_if #(.SCORE_W(10)) bus ();

  score_keeper #(.WIN_SCORE(WIN), .SERVE_FRAMES(SF), .SCORE_W(10)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: game phase plus scores, derived from the game rules.
  localparam int PH_IDLE = 0, PH_WAIT = 1, PH_LIVE = 2, PH_POINT = 3, PH_END = 4;
  int phase, s1, s2, frames_left, owed;
  int released, champ;
  bit last_start, last_g1, last_g2;

  always @(posedge clock) begin
    bit st, e1, e2;
    if (reset) begin
      phase = PH_IDLE; s1 = 0; s2 = 0; frames_left = 0; owed = 0;
      released = 0; champ = 0;
      last_start = 0; last_g1 = 0; last_g2 = 0;
    end else begin
      st = bus.start   && !last_start;
      e1 = bus.goal_p1 && !last_g1;
      e2 = bus.goal_p2 && !last_g2;
      released = 0;
      if (bus.menu) begin
        phase = PH_IDLE; owed = 0; frames_left = 0;
      end else if (phase == PH_IDLE || phase == PH_END) begin
        if (st) begin
          s1 = 0; s2 = 0; champ = 0; frames_left = SF; phase = PH_WAIT;
        end
      end else if (phase == PH_WAIT) begin
        if (bus.frame_tick) begin
          frames_left = frames_left - 1;
          if (frames_left == 0) begin phase = PH_LIVE; released = 1; end
        end
      end else if (phase == PH_LIVE) begin
        if (e1 && e2)  begin frames_left = SF; phase = PH_WAIT; end
        else if (e1)   begin owed = 1; phase = PH_POINT; end
        else if (e2)   begin owed = 2; phase = PH_POINT; end
      end else if (phase == PH_POINT) begin
        if (bus.frame_tick) begin
          if (owed == 1 && s1 < WIN) s1 = s1 + 1;
          if (owed == 2 && s2 < WIN) s2 = s2 + 1;
          if ((owed == 1 ? s1 : s2) == WIN) begin champ = owed; phase = PH_END; end
          else begin frames_left = SF; phase = PH_WAIT; end
          owed = 0;
        end
      end
      last_start = bus.start; last_g1 = bus.goal_p1; last_g2 = bus.goal_p2;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("score1",       int'(bus.score1),       s1);
      chk("score2",       int'(bus.score2),       s2);
      chk("ball_release", int'(bus.ball_release), released);
      chk("playing",      int'(bus.playing),      int'(phase == PH_LIVE));
      chk("game_over",    int'(bus.game_over),    int'(phase == PH_END));
      chk("winner",       int'(bus.winner),       champ);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // One-cycle frame tick; returns at the negedge after the tick was sampled.
  task automatic tick();
    bus.frame_tick = 1'b1;
    cyc(1);
    bus.frame_tick = 1'b0;
  endtask

  // Run n serve ticks; the last one must release the ball.
  task automatic serve_out(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(3);
      tick();
      if (i == n - 1) begin
        chk("lit_release_hi", int'(bus.ball_release), 1);
        chk("lit_playing_hi", int'(bus.playing), 1);
      end else begin
        chk("lit_release_lo", int'(bus.ball_release), 0);
      end
    end
    cyc(1);
    chk("lit_release_once", int'(bus.ball_release), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, vectors %0d", vectors);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.frame_tick = 1'b0; bus.goal_p1 = 1'b0; bus.goal_p2 = 1'b0;
    bus.menu = 1'b0; bus.start = 1'b0;
    cyc(3);
    chk_en = 1'b1;
    chk("lit_rst_score1", int'(bus.score1), 0);
    chk("lit_rst_playing", int'(bus.playing), 0);
    chk("lit_rst_winner", int'(bus.winner), 0);
    reset = 1'b0;
    cyc(2);

    // Start, then release on the third tick.
    bus.start = 1'b1; cyc(2); bus.start = 1'b0;
    serve_out(SF);

    // Goal held for 50 cycles counts once, committed at the next tick.
    bus.goal_p1 = 1'b1;
    cyc(50);
    chk("lit_goal_before_tick", int'(bus.score1), 0);
    tick();
    chk("lit_goal_at_tick", int'(bus.score1), 1);
    chk("lit_goal_not_playing", int'(bus.playing), 0);
    cyc(3);
    tick();
    chk("lit_goal_single_inc", int'(bus.score1), 1);
    bus.goal_p1 = 1'b0;
    serve_out(SF - 1);

    // Simultaneous goals: no point, re-serve.
    bus.goal_p1 = 1'b1; bus.goal_p2 = 1'b1;
    cyc(2);
    bus.goal_p1 = 1'b0; bus.goal_p2 = 1'b0;
    chk("lit_both_s1", int'(bus.score1), 1);
    chk("lit_both_s2", int'(bus.score2), 0);
    serve_out(SF);

    // Menu during a pending point discards it.
    bus.goal_p1 = 1'b1; cyc(1); bus.goal_p1 = 1'b0;
    bus.menu = 1'b1; cyc(2); bus.menu = 1'b0;
    cyc(2); tick(); cyc(2); tick();
    chk("lit_menu_no_inc", int'(bus.score1), 1);
    bus.start = 1'b1; cyc(1); bus.start = 1'b0; cyc(1);
    chk("lit_menu_restart_s1", int'(bus.score1), 0);
    serve_out(SF);

    // Player 2 wins 0/5.
    for (int i = 0; i < WIN; i++) begin
      bus.goal_p2 = 1'b1; cyc(2); bus.goal_p2 = 1'b0; cyc(1);
      tick();
      if (i < WIN - 1) begin
        cyc(1);
        serve_out(SF);
      end
    end
    chk("lit_win_s2", int'(bus.score2), 5);
    chk("lit_win_over", int'(bus.game_over), 1);
    chk("lit_win_code", int'(bus.winner), 2);
    bus.goal_p2 = 1'b1; bus.goal_p1 = 1'b1; cyc(2);
    bus.goal_p2 = 1'b0; bus.goal_p1 = 1'b0; cyc(1);
    tick(); cyc(2); tick();
    chk("lit_over_hold_s1", int'(bus.score1), 0);
    chk("lit_over_hold_s2", int'(bus.score2), 5);

    // Restart from game over, then reset mid-serve.
    bus.start = 1'b1; cyc(1); bus.start = 1'b0; cyc(1);
    chk("lit_restart_winner", int'(bus.winner), 0);
    chk("lit_restart_s2", int'(bus.score2), 0);
    tick(); cyc(1);
    reset = 1'b1; cyc(1); reset = 1'b0;
    chk("lit_midreset_over", int'(bus.game_over), 0);
    for (int i = 0; i < 4; i++) begin
      cyc(2); tick();
      chk("lit_no_release", int'(bus.ball_release), 0);
    end
    chk("lit_end_playing", int'(bus.playing), 0);
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
